// File: rtl/polaris_gpio_pkg.sv
// polaris_gpio_pkg
//   Shared definitions for the polaris GPIO bank: TL-UL opcodes, the
//   register word-address map and the byte-mask expansion helper.
package polaris_gpio_pkg;

    localparam logic [2:0] PUT_FULL    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;
    localparam logic [2:0] GET         = 3'd4;
    localparam logic [2:0] ACK         = 3'd0;
    localparam logic [2:0] ACK_DATA    = 3'd1;

    typedef enum logic [3:0] {
        REG_OUT  = 4'd0,
        REG_TRI  = 4'd1,
        REG_IN   = 4'd2,
        REG_SET  = 4'd3,
        REG_CLR  = 4'd4,
        REG_TGL  = 4'd5,
        REG_IE   = 4'd6,
        REG_RISE = 4'd7,
        REG_FALL = 4'd8,
        REG_IP   = 4'd9
    } gpio_reg_e;

    // Highest mapped word address; 10..15 respond denied.
    localparam logic [3:0] REG_LAST = 4'd9;

    function automatic logic [31:0] expand_mask(input logic [3:0] mask);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = {8{mask[i]}};
        end
        return res;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge
//   Input synchroniser plus edge detector for the GPIO pads.
//   clk_i       : clock
//   rst_ni      : synchronous active-low reset
//   async_i     : raw pad inputs
//   rise_en_i   : per-pin rising-edge enable
//   fall_en_i   : per-pin falling-edge enable
//   in_o        : synchronised input value (last chain stage)
//   rise_o      : per-pin rising-edge event (one cycle)
//   fall_o      : per-pin falling-edge event (one cycle)
module gpio_sync_edge #(
    parameter int W      = 32,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] async_i,
    input  logic [W-1:0] rise_en_i,
    input  logic [W-1:0] fall_en_i,
    output logic [W-1:0] in_o,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);

    // The chain and prev register come out of reset at 0, so a pad already
    // high would look like a rising edge; events stay masked until the chain
    // and prev have both been filled from the real pads.
    localparam int PRIME_MAX = STAGES + 1;
    localparam int CNT_W     = $clog2(PRIME_MAX + 1);

    logic [STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]             prev_q;
    logic [CNT_W-1:0]         prime_q;
    logic [CNT_W-1:0]         prime_d;
    logic                     primed;

    assign primed  = (prime_q == CNT_W'(PRIME_MAX));
    assign prime_d = primed ? prime_q : prime_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            prev_q  <= '0;
            prime_q <= '0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], async_i};
            prev_q  <= sync_q[STAGES-1];
            prime_q <= prime_d;
        end
    end

    assign in_o   = sync_q[STAGES-1];
    assign rise_o = primed ? ( in_o & ~prev_q & rise_en_i) : '0;
    assign fall_o = primed ? (~in_o &  prev_q & fall_en_i) : '0;

endmodule

// File: rtl/polaris_gpio_irq.sv
// polaris_gpio_irq
//   TL-UL slave GPIO bank with atomic SET/CLR/TGL, byte-masked writes,
//   synchronised inputs and per-pin rise/fall edge interrupts.
//   gpio_clock_i / gpio_resetn_i : clock, synchronous active-low reset
//   gpio_a_*                     : TL-UL A channel (address is a word index)
//   gpio_d_*                     : TL-UL D channel, single response register
//   outputs_o                    : pin output values (OUT)
//   t_o                          : tristate per pin, 1 = high-Z (TRI)
//   inputs_i                     : asynchronous pad inputs
//   irq_o                        : registered |(IP & IE)
module polaris_gpio_irq
    import polaris_gpio_pkg::*;
#(
    parameter int          TL_RS       = 4,
    parameter int          GPIO_W      = 32,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] OUT_RESET   = 32'h0
) (
    input  logic              gpio_clock_i,
    input  logic              gpio_resetn_i,
    input  logic [2:0]        gpio_a_opcode,
    input  logic [2:0]        gpio_a_param,
    input  logic [3:0]        gpio_a_size,
    input  logic [TL_RS-1:0]  gpio_a_source,
    input  logic [3:0]        gpio_a_address,
    input  logic [3:0]        gpio_a_mask,
    input  logic [31:0]       gpio_a_data,
    input  logic              gpio_a_corrupt,
    input  logic              gpio_a_valid,
    output logic              gpio_a_ready,
    output logic [2:0]        gpio_d_opcode,
    output logic [1:0]        gpio_d_param,
    output logic [3:0]        gpio_d_size,
    output logic [TL_RS-1:0]  gpio_d_source,
    output logic              gpio_d_denied,
    output logic [31:0]       gpio_d_data,
    output logic              gpio_d_corrupt,
    output logic              gpio_d_valid,
    input  logic              gpio_d_ready,
    output logic [GPIO_W-1:0] outputs_o,
    output logic [GPIO_W-1:0] t_o,
    input  logic [GPIO_W-1:0] inputs_i,
    output logic              irq_o
);

    logic [GPIO_W-1:0] out_q, out_d;
    logic [GPIO_W-1:0] tri_q, tri_d;
    logic [GPIO_W-1:0] ie_q, ie_d;
    logic [GPIO_W-1:0] rise_q, rise_d;
    logic [GPIO_W-1:0] fall_q, fall_d;
    logic [GPIO_W-1:0] ip_q, ip_d;
    logic [GPIO_W-1:0] ip_clr;
    logic              irq_q;

    logic [GPIO_W-1:0] in_sync, rise_ev, fall_ev;

    logic              d_valid_q;
    logic [2:0]        d_opcode_q;
    logic [3:0]        d_size_q;
    logic [TL_RS-1:0]  d_source_q;
    logic              d_denied_q;
    logic [31:0]       d_data_q;

    logic              accept, is_get, is_put, mapped, denied, wr_en;
    gpio_reg_e         reg_sel;
    logic [31:0]       wmask_full, wd_full, rdata;
    logic [GPIO_W-1:0] wm, wd;

    // a_param carries no meaning for Get/Put and is intentionally ignored.
    logic unused_a_param;
    assign unused_a_param = ^gpio_a_param;

    gpio_sync_edge #(
        .W      (GPIO_W),
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i     (gpio_clock_i),
        .rst_ni    (gpio_resetn_i),
        .async_i   (inputs_i),
        .rise_en_i (rise_q),
        .fall_en_i (fall_q),
        .in_o      (in_sync),
        .rise_o    (rise_ev),
        .fall_o    (fall_ev)
    );

    assign gpio_a_ready = !d_valid_q || gpio_d_ready;
    assign accept       = gpio_a_valid && gpio_a_ready;

    assign is_get  = (gpio_a_opcode == GET);
    assign is_put  = (gpio_a_opcode == PUT_FULL) || (gpio_a_opcode == PUT_PARTIAL);
    assign mapped  = (gpio_a_address <= REG_LAST);
    assign reg_sel = gpio_reg_e'(gpio_a_address);
    assign denied  = !(is_get || is_put) || gpio_a_corrupt || !mapped ||
                     (is_put && reg_sel == REG_IN);
    assign wr_en   = accept && is_put && !denied;

    assign wmask_full = expand_mask(gpio_a_mask);
    assign wd_full    = gpio_a_data & wmask_full;
    assign wm         = wmask_full[GPIO_W-1:0];
    assign wd         = wd_full[GPIO_W-1:0];

    always_comb begin
        out_d  = out_q;
        tri_d  = tri_q;
        ie_d   = ie_q;
        rise_d = rise_q;
        fall_d = fall_q;
        ip_clr = '0;
        if (wr_en) begin
            case (reg_sel)
                REG_OUT:  out_d  = (out_q  & ~wm) | wd;
                REG_TRI:  tri_d  = (tri_q  & ~wm) | wd;
                REG_SET:  out_d  = out_q | wd;
                REG_CLR:  out_d  = out_q & ~wd;
                REG_TGL:  out_d  = out_q ^ wd;
                REG_IE:   ie_d   = (ie_q   & ~wm) | wd;
                REG_RISE: rise_d = (rise_q & ~wm) | wd;
                REG_FALL: fall_d = (fall_q & ~wm) | wd;
                REG_IP:   ip_clr = wd;
                default:  ;
            endcase
        end
        // New events are ORed in after the clear so a coincident edge survives.
        ip_d = (ip_q & ~ip_clr) | rise_ev | fall_ev;
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_OUT:  rdata = 32'(out_q);
            REG_TRI:  rdata = 32'(tri_q);
            REG_IN:   rdata = 32'(in_sync);
            REG_IE:   rdata = 32'(ie_q);
            REG_RISE: rdata = 32'(rise_q);
            REG_FALL: rdata = 32'(fall_q);
            REG_IP:   rdata = 32'(ip_q);
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge gpio_clock_i) begin
        if (!gpio_resetn_i) begin
            out_q  <= OUT_RESET[GPIO_W-1:0];
            tri_q  <= '1;
            ie_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            ip_q   <= '0;
            irq_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            tri_q  <= tri_d;
            ie_q   <= ie_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            ip_q   <= ip_d;
            irq_q  <= |(ip_q & ie_q);
        end
    end

    always_ff @(posedge gpio_clock_i) begin
        if (!gpio_resetn_i) begin
            d_valid_q  <= 1'b0;
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_denied_q <= 1'b0;
            d_data_q   <= '0;
        end else if (accept) begin
            d_valid_q  <= 1'b1;
            d_opcode_q <= is_get ? ACK_DATA : ACK;
            d_size_q   <= gpio_a_size;
            d_source_q <= gpio_a_source;
            d_denied_q <= denied;
            d_data_q   <= (is_get && !denied) ? rdata : '0;
        end else if (gpio_d_ready) begin
            d_valid_q  <= 1'b0;
        end
    end

    assign gpio_d_valid   = d_valid_q;
    assign gpio_d_opcode  = d_opcode_q;
    assign gpio_d_param   = '0;
    assign gpio_d_size    = d_size_q;
    assign gpio_d_source  = d_source_q;
    assign gpio_d_denied  = d_denied_q;
    assign gpio_d_data    = d_data_q;
    assign gpio_d_corrupt = 1'b0;

    assign outputs_o = out_q;
    assign t_o       = tri_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_polaris_gpio_irq.sv
// tb_polaris_gpio_irq
//   Directed bench for polaris_gpio_irq (GPIO_W=32, SYNC_STAGES=2, OUT_RESET=0).
//   All stimulus changes and all sampling happen 1 time unit after a rising edge.
module tb_polaris_gpio_irq;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [3:0]  a_size;
    logic [3:0]  a_source;
    logic [3:0]  a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [3:0]  d_source;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] outputs;
    logic [31:0] t_out;
    logic [31:0] inputs;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    polaris_gpio_irq #(
        .TL_RS       (4),
        .GPIO_W      (32),
        .SYNC_STAGES (2),
        .OUT_RESET   (32'h0)
    ) dut (
        .gpio_clock_i   (clk),
        .gpio_resetn_i  (rstn),
        .gpio_a_opcode  (a_opcode),
        .gpio_a_param   (a_param),
        .gpio_a_size    (a_size),
        .gpio_a_source  (a_source),
        .gpio_a_address (a_address),
        .gpio_a_mask    (a_mask),
        .gpio_a_data    (a_data),
        .gpio_a_corrupt (a_corrupt),
        .gpio_a_valid   (a_valid),
        .gpio_a_ready   (a_ready),
        .gpio_d_opcode  (d_opcode),
        .gpio_d_param   (d_param),
        .gpio_d_size    (d_size),
        .gpio_d_source  (d_source),
        .gpio_d_denied  (d_denied),
        .gpio_d_data    (d_data),
        .gpio_d_corrupt (d_corrupt),
        .gpio_d_valid   (d_valid),
        .gpio_d_ready   (d_ready),
        .outputs_o      (outputs),
        .t_o            (t_out),
        .inputs_i       (inputs),
        .irq_o          (irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request; on return the response for it is on the D channel.
    task automatic tl_req(input logic [2:0] op, input logic [3:0] addr,
                          input logic [31:0] data, input logic [3:0] mask,
                          input logic corrupt, input logic [3:0] src);
        a_opcode  = op;
        a_address = addr;
        a_data    = data;
        a_mask    = mask;
        a_corrupt = corrupt;
        a_source  = src;
        a_valid   = 1'b1;
        tick();
        a_valid   = 1'b0;
        a_corrupt = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL rst_d_valid: got %b want 0", d_valid); end
        checks++; if (outputs !== 32'h0) begin errors++; $display("FAIL rst_out: got %h want 00000000", outputs); end
        checks++; if (t_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_tri: got %h want ffffffff", t_out); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready: got %b want 1", a_ready); end
        rstn = 1'b1;
        tl_req(3'd4, 4'd1, 32'h0, 4'hF, 1'b0, 4'd5);
        checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL get_tri_valid: got %b want 1", d_valid); end
        checks++; if (d_opcode !== 3'd1) begin errors++; $display("FAIL get_tri_opcode: got %0d want 1", d_opcode); end
        checks++; if (d_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL get_tri_data: got %h want ffffffff", d_data); end
        checks++; if (d_source !== 4'd5) begin errors++; $display("FAIL get_tri_source: got %0d want 5", d_source); end
        checks++; if (d_size !== 4'd2) begin errors++; $display("FAIL get_tri_size: got %0d want 2", d_size); end
        checks++; if (d_denied !== 1'b0 || d_param !== 2'd0 || d_corrupt !== 1'b0) begin
            errors++; $display("FAIL get_tri_flags: got denied=%b param=%0d corrupt=%b want 0/0/0", d_denied, d_param, d_corrupt);
        end
        tl_req(3'd4, 4'd0, 32'h0, 4'hF, 1'b0, 4'd6);
        checks++; if (d_data !== 32'h0) begin errors++; $display("FAIL get_out_reset: got %h want 00000000", d_data); end
    endtask

    task automatic test_out_ops();
        tl_req(3'd0, 4'd0, 32'h0000_00F0, 4'hF, 1'b0, 4'd1);
        checks++; if (d_opcode !== 3'd0 || d_denied !== 1'b0) begin
            errors++; $display("FAIL put_ack: got opcode=%0d denied=%b want 0/0", d_opcode, d_denied);
        end
        tl_req(3'd0, 4'd3, 32'h0000_000F, 4'hF, 1'b0, 4'd1);
        tl_req(3'd0, 4'd4, 32'h0000_0030, 4'hF, 1'b0, 4'd1);
        tl_req(3'd0, 4'd5, 32'h0000_0101, 4'hF, 1'b0, 4'd1);
        checks++; if (outputs !== 32'h0000_01CE) begin errors++; $display("FAIL set_clr_tgl_out: got %h want 000001ce", outputs); end
        tl_req(3'd4, 4'd0, 32'h0, 4'hF, 1'b0, 4'd2);
        checks++; if (d_data !== 32'h0000_01CE) begin errors++; $display("FAIL get_out_ops: got %h want 000001ce", d_data); end
        tl_req(3'd4, 4'd3, 32'h0, 4'hF, 1'b0, 4'd2);
        checks++; if (d_data !== 32'h0 || d_denied !== 1'b0) begin
            errors++; $display("FAIL get_set_wo: got data=%h denied=%b want 00000000/0", d_data, d_denied);
        end
        tl_req(3'd0, 4'd1, 32'h0000_FFFF, 4'hF, 1'b0, 4'd1);
        checks++; if (t_out !== 32'h0000_FFFF) begin errors++; $display("FAIL tri_write: got %h want 0000ffff", t_out); end
    endtask

    task automatic test_partial();
        tl_req(3'd0, 4'd0, 32'h0, 4'hF, 1'b0, 4'd1);
        tl_req(3'd1, 4'd0, 32'hAABB_CCDD, 4'b0100, 1'b0, 4'd1);
        checks++; if (outputs !== 32'h00BB_0000) begin errors++; $display("FAIL partial_out: got %h want 00bb0000", outputs); end
        tl_req(3'd1, 4'd3, 32'hFFFF_FFFF, 4'b0001, 1'b0, 4'd1);
        checks++; if (outputs !== 32'h00BB_00FF) begin errors++; $display("FAIL partial_set: got %h want 00bb00ff", outputs); end
    endtask

    task automatic test_denied();
        tl_req(3'd4, 4'd12, 32'h0, 4'hF, 1'b0, 4'd7);
        checks++; if (d_denied !== 1'b1 || d_data !== 32'h0 || d_opcode !== 3'd1) begin
            errors++; $display("FAIL deny_unmapped: got denied=%b data=%h opcode=%0d want 1/00000000/1", d_denied, d_data, d_opcode);
        end
        tl_req(3'd0, 4'd2, 32'hFFFF_FFFF, 4'hF, 1'b0, 4'd7);
        checks++; if (d_denied !== 1'b1 || d_opcode !== 3'd0) begin
            errors++; $display("FAIL deny_put_in: got denied=%b opcode=%0d want 1/0", d_denied, d_opcode);
        end
        tl_req(3'd2, 4'd0, 32'h0, 4'hF, 1'b0, 4'd7);
        checks++; if (d_denied !== 1'b1) begin errors++; $display("FAIL deny_opcode: got %b want 1", d_denied); end
        tl_req(3'd0, 4'd0, 32'h1234_5678, 4'hF, 1'b1, 4'd7);
        checks++; if (d_denied !== 1'b1) begin errors++; $display("FAIL deny_corrupt: got %b want 1", d_denied); end
        checks++; if (outputs !== 32'h00BB_00FF) begin errors++; $display("FAIL deny_no_change: got %h want 00bb00ff", outputs); end
        tl_req(3'd4, 4'd0, 32'h0, 4'hF, 1'b0, 4'd7);
        checks++; if (d_data !== 32'h00BB_00FF || d_denied !== 1'b0) begin
            errors++; $display("FAIL deny_readback: got data=%h denied=%b want 00bb00ff/0", d_data, d_denied);
        end
    endtask

    task automatic test_irq();
        tl_req(3'd0, 4'd7, 32'h1, 4'hF, 1'b0, 4'd0);
        tl_req(3'd0, 4'd6, 32'h1, 4'hF, 1'b0, 4'd0);
        tick();
        tick();
        inputs[0] = 1'b1;                    // edge k
        tick();                              // k+1
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b want 0", irq); end
        tick();                              // k+2
        a_opcode  = 3'd4;
        a_address = 4'd9;
        a_mask    = 4'hF;
        a_source  = 4'd1;
        a_valid   = 1'b1;
        tick();                              // k+3: read sees IP before set
        checks++; if (d_data !== 32'h0 || irq !== 1'b0) begin
            errors++; $display("FAIL ip_k3: got data=%h irq=%b want 00000000/0", d_data, irq);
        end
        a_source = 4'd2;
        tick();                              // k+4
        a_valid  = 1'b0;
        checks++; if (d_data !== 32'h1 || d_source !== 4'd2) begin
            errors++; $display("FAIL ip_k4: got data=%h src=%0d want 00000001/2", d_data, d_source);
        end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_k4: got %b want 1", irq); end
        tl_req(3'd0, 4'd9, 32'h1, 4'hF, 1'b0, 4'd0);
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b want 0", irq); end
        // W1C lands on the same edge that sets IP from a new rising edge.
        inputs[0] = 1'b0;
        repeat (5) tick();
        inputs[0] = 1'b1;                    // edge k
        tick();
        tick();                              // k+2
        tl_req(3'd0, 4'd9, 32'h1, 4'hF, 1'b0, 4'd0);  // accepted at k+3
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_w1c_race: got %b want 1", irq); end
        tl_req(3'd4, 4'd9, 32'h0, 4'hF, 1'b0, 4'd0);
        checks++; if (d_data !== 32'h1) begin errors++; $display("FAIL ip_w1c_race: got %h want 00000001", d_data); end
        tl_req(3'd0, 4'd9, 32'h1, 4'hF, 1'b0, 4'd0);
        tl_req(3'd0, 4'd8, 32'h1, 4'hF, 1'b0, 4'd0);
        inputs[0] = 1'b0;
        repeat (5) tick();
        tl_req(3'd4, 4'd9, 32'h0, 4'hF, 1'b0, 4'd0);
        checks++; if (d_data !== 32'h1 || irq !== 1'b1) begin
            errors++; $display("FAIL ip_fall: got data=%h irq=%b want 00000001/1", d_data, irq);
        end
        tl_req(3'd0, 4'd6, 32'h0, 4'hF, 1'b0, 4'd0);
        tl_req(3'd0, 4'd9, 32'hFFFF_FFFF, 4'hF, 1'b0, 4'd0);
        tick();
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_ie_off: got %b want 0", irq); end
    endtask

    task automatic test_back_to_back();
        d_ready   = 1'b0;
        a_opcode  = 3'd4;
        a_address = 4'd0;
        a_mask    = 4'hF;
        a_source  = 4'd3;
        a_valid   = 1'b1;
        tick();
        a_source = 4'd4;
        checks++; if (d_valid !== 1'b1 || d_source !== 4'd3 || a_ready !== 1'b0) begin
            errors++; $display("FAIL stall_first: got valid=%b src=%0d a_ready=%b want 1/3/0", d_valid, d_source, a_ready);
        end
        tick();
        tick();
        checks++; if (d_valid !== 1'b1 || d_source !== 4'd3 || d_data !== 32'h00BB_00FF || a_ready !== 1'b0) begin
            errors++; $display("FAIL stall_hold: got valid=%b src=%0d data=%h a_ready=%b want 1/3/00bb00ff/0", d_valid, d_source, d_data, a_ready);
        end
        d_ready = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL release_a_ready: got %b want 1", a_ready); end
        tick();
        checks++; if (d_valid !== 1'b1 || d_source !== 4'd4) begin
            errors++; $display("FAIL b2b_second: got valid=%b src=%0d want 1/4", d_valid, d_source);
        end
        a_source = 4'd5;
        tick();
        a_valid = 1'b0;
        checks++; if (d_valid !== 1'b1 || d_source !== 4'd5) begin
            errors++; $display("FAIL b2b_third: got valid=%b src=%0d want 1/5", d_valid, d_source);
        end
        tick();
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", d_valid); end
    endtask

    task automatic test_prime();
        d_ready = 1'b0;
        tl_req(3'd4, 4'd0, 32'h0, 4'hF, 1'b0, 4'd9);
        rstn   = 1'b0;
        inputs = 32'h1;
        tick();
        checks++; if (d_valid !== 1'b0 || outputs !== 32'h0) begin
            errors++; $display("FAIL rst_mid_xact: got valid=%b out=%h want 0/00000000", d_valid, outputs);
        end
        d_ready = 1'b1;
        tick();
        rstn = 1'b1;
        tl_req(3'd0, 4'd7, 32'h1, 4'hF, 1'b0, 4'd0);   // RISE[0] set on first edge
        repeat (6) tick();
        tl_req(3'd4, 4'd9, 32'h0, 4'hF, 1'b0, 4'd0);
        checks++; if (d_data !== 32'h0) begin errors++; $display("FAIL prime_suppress: got %h want 00000000", d_data); end
        inputs = 32'h0;
        repeat (4) tick();
        inputs = 32'h1;
        repeat (5) tick();
        tl_req(3'd4, 4'd9, 32'h0, 4'hF, 1'b0, 4'd0);
        checks++; if (d_data !== 32'h1) begin errors++; $display("FAIL prime_live: got %h want 00000001", d_data); end
    endtask

    initial begin
        rstn      = 1'b0;
        a_opcode  = 3'd0;
        a_param   = 3'd0;
        a_size    = 4'd2;
        a_source  = 4'd0;
        a_address = 4'd0;
        a_mask    = 4'hF;
        a_data    = 32'h0;
        a_corrupt = 1'b0;
        a_valid   = 1'b0;
        d_ready   = 1'b1;
        inputs    = 32'h0;
        tick();
        test_reset();
        test_out_ops();
        test_partial();
        test_denied();
        test_irq();
        test_back_to_back();
        test_prime();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
